// File: rtl/pio_loader.sv
// rtl/pio_loader.sv - configuration sequencer that loads a program and brings up one pio state machine
//
// Purpose:
//   On an accepted start, copies PLEN instructions from a synchronous
//   program ROM into pio instruction memory. It then writes PEND, DIV, GRPS
//   and SHIFT for the selected machine, and finally issues EN to enable it.
//
// Ports:
//   i_clk, i_reset      clock, synchronous active-high reset
//   i_start             single-cycle load request, ignored while busy/done
//   i_plen              instruction count 0..2**PROG_AW
//   i_sm_sel            target state machine
//   i_exec_ctrl, i_div, i_pin_grps, i_shift_ctrl, i_en_mask
//                       configuration words, latched on accepted start
//   o_prog_addr         program ROM address
//   i_prog_data         ROM data, valid one cycle after o_prog_addr
//   o_action, o_index, o_mindex, o_din
//                       pio command port, each command held one cycle
//   o_busy, o_done, o_err
//                       status: load in progress, EN issued, bad length

module pio_loader #(
    parameter int PROG_AW = 5
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic               i_start,
    input  logic [PROG_AW:0]   i_plen,
    input  logic [1:0]         i_sm_sel,
    input  logic [31:0]        i_exec_ctrl,
    input  logic [23:0]        i_div,
    input  logic [31:0]        i_pin_grps,
    input  logic [31:0]        i_shift_ctrl,
    input  logic [3:0]         i_en_mask,
    output logic [PROG_AW-1:0] o_prog_addr,
    input  logic [15:0]        i_prog_data,
    output logic [3:0]         o_action,
    output logic [4:0]         o_index,
    output logic [1:0]         o_mindex,
    output logic [31:0]        o_din,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_err
);

    localparam logic [3:0] ACT_NONE  = 4'd0;
    localparam logic [3:0] ACT_INSTR = 4'd1;
    localparam logic [3:0] ACT_PEND  = 4'd2;
    localparam logic [3:0] ACT_GRPS  = 4'd5;
    localparam logic [3:0] ACT_EN    = 4'd6;
    localparam logic [3:0] ACT_DIV   = 4'd7;
    localparam logic [3:0] ACT_SHIFT = 4'd10;

    localparam logic [PROG_AW:0] MAX_LEN = {1'b1, {PROG_AW{1'b0}}};

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_FETCH,
        ST_LOAD,
        ST_PEND,
        ST_DIV,
        ST_GRPS,
        ST_SHIFT,
        ST_EN,
        ST_DONE
    } state_t;

    state_t             r_state;
    logic [PROG_AW:0]   r_i;
    logic [PROG_AW:0]   r_plen;
    logic [31:0]        r_exec_ctrl;
    logic [23:0]        r_div;
    logic [31:0]        r_pin_grps;
    logic [31:0]        r_shift_ctrl;
    logic [3:0]         r_en_mask;
    logic [PROG_AW-1:0] r_prog_addr;
    logic [3:0]         r_action;
    logic [4:0]         r_index;
    logic [1:0]         r_mindex;
    logic [31:0]        r_din;
    logic               r_busy;
    logic               r_done;
    logic               r_err;

    logic [PROG_AW:0]   w_i_next;
    logic               w_last;

    // The counter is one bit wider than the ROM address, so a full-length
    // program ends at i = 2**PROG_AW - 1 without wrapping.
    assign w_i_next = r_i + 1'b1;
    assign w_last   = (r_i == r_plen - 1'b1);

    // Outputs are loaded on the edge that enters a state, so the command
    // on the port always belongs to the state currently held.
    // The ROM address is advanced one step ahead. The word for instruction i
    // is therefore on i_prog_data while in FETCH for i, and is captured on
    // the edge into LOAD. The address is parked at 0 while idle, so the first
    // word is already available in the cycle after start.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state      <= ST_IDLE;
            r_i          <= '0;
            r_plen       <= '0;
            r_exec_ctrl  <= '0;
            r_div        <= '0;
            r_pin_grps   <= '0;
            r_shift_ctrl <= '0;
            r_en_mask    <= '0;
            r_prog_addr  <= '0;
            r_action     <= ACT_NONE;
            r_index      <= '0;
            r_mindex     <= '0;
            r_din        <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_err        <= 1'b0;
        end else begin
            r_action <= ACT_NONE;
            r_index  <= '0;
            r_din    <= '0;
            r_done   <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        if (i_plen > MAX_LEN) begin
                            r_err <= 1'b1;
                        end else begin
                            r_err        <= 1'b0;
                            r_busy       <= 1'b1;
                            r_plen       <= i_plen;
                            r_mindex     <= i_sm_sel;
                            r_exec_ctrl  <= i_exec_ctrl;
                            r_div        <= i_div;
                            r_pin_grps   <= i_pin_grps;
                            r_shift_ctrl <= i_shift_ctrl;
                            r_en_mask    <= i_en_mask;
                            r_i          <= '0;
                            if (i_plen == '0) begin
                                r_state  <= ST_PEND;
                                r_action <= ACT_PEND;
                                r_din    <= i_exec_ctrl;
                            end else begin
                                r_state  <= ST_FETCH;
                            end
                        end
                    end
                end
                ST_FETCH: begin
                    r_state     <= ST_LOAD;
                    r_action    <= ACT_INSTR;
                    r_index     <= 5'(r_i);
                    r_din       <= {16'h0, i_prog_data};
                    r_prog_addr <= w_last ? '0 : w_i_next[PROG_AW-1:0];
                end
                ST_LOAD: begin
                    if (w_last) begin
                        r_state  <= ST_PEND;
                        r_action <= ACT_PEND;
                        r_din    <= r_exec_ctrl;
                    end else begin
                        r_i     <= w_i_next;
                        r_state <= ST_FETCH;
                    end
                end
                ST_PEND: begin
                    r_state  <= ST_DIV;
                    r_action <= ACT_DIV;
                    r_din    <= {8'h0, r_div};
                end
                ST_DIV: begin
                    r_state  <= ST_GRPS;
                    r_action <= ACT_GRPS;
                    r_din    <= r_pin_grps;
                end
                ST_GRPS: begin
                    r_state  <= ST_SHIFT;
                    r_action <= ACT_SHIFT;
                    r_din    <= r_shift_ctrl;
                end
                ST_SHIFT: begin
                    r_state  <= ST_EN;
                    r_action <= ACT_EN;
                    r_din    <= {28'h0, r_en_mask};
                end
                ST_EN: begin
                    r_state <= ST_DONE;
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign o_prog_addr = r_prog_addr;
    assign o_action    = r_action;
    assign o_index     = r_index;
    assign o_mindex    = r_mindex;
    assign o_din       = r_din;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_err       = r_err;

endmodule

// File: tb/tb_pio_loader.sv
// tb/tb_pio_loader.sv - randomized self-checking bench for pio_loader
module tb_pio_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [5:0]  plen;
    logic [1:0]  sm_sel;
    logic [31:0] exec_ctrl;
    logic [23:0] div;
    logic [31:0] pin_grps;
    logic [31:0] shift_ctrl;
    logic [3:0]  en_mask;
    logic [4:0]  prog_addr;
    logic [15:0] prog_data;
    logic [3:0]  action;
    logic [4:0]  index;
    logic [1:0]  mindex;
    logic [31:0] din;
    logic        busy;
    logic        done;
    logic        err;

    logic [15:0] rom [32];

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    always_ff @(posedge clk) prog_data <= rom[prog_addr];

    pio_loader #(.PROG_AW(5)) dut (
        .i_clk(clk), .i_reset(reset), .i_start(start), .i_plen(plen),
        .i_sm_sel(sm_sel), .i_exec_ctrl(exec_ctrl), .i_div(div),
        .i_pin_grps(pin_grps), .i_shift_ctrl(shift_ctrl), .i_en_mask(en_mask),
        .o_prog_addr(prog_addr), .i_prog_data(prog_data), .o_action(action),
        .o_index(index), .o_mindex(mindex), .o_din(din), .o_busy(busy),
        .o_done(done), .o_err(err)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic rand_cfg();
        sm_sel     = 2'($urandom_range(0, 3));
        exec_ctrl  = $urandom;
        div        = 24'($urandom);
        pin_grps   = $urandom;
        shift_ctrl = $urandom;
        en_mask    = 4'($urandom);
    endtask

    task automatic rand_rom();
        for (int k = 0; k < 32; k++) rom[k] = 16'($urandom);
    endtask

    // Expected behaviour, counted from the start cycle c=0:
    // INSTR k at cycle 2+2k, then PEND..EN at 2*plen+1..2*plen+5, done at 2*plen+6.
    task automatic run_load(input int disturb_at, input int reset_at, input bit start_at_done);
        int          pl;
        logic [1:0]  sm;
        logic [31:0] ex, gr, sh, dvw, enw;
        int          last;
        bit          aborted;
        logic [3:0]  e_act;
        int          e_idx;
        logic [31:0] e_din;
        pl  = int'(plen);
        sm  = sm_sel;
        ex  = exec_ctrl;
        dvw = {8'h0, div};
        gr  = pin_grps;
        sh  = shift_ctrl;
        enw = {28'h0, en_mask};
        last = 2 * pl + 6;
        aborted = 1'b0;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int c = 1; c <= last; c++) begin
            e_act = 4'd0; e_idx = 0; e_din = 32'h0;
            if (c >= 2 && c <= 2 * pl && (c % 2) == 0) begin
                e_act = 4'd1; e_idx = (c - 2) / 2; e_din = {16'h0, rom[e_idx]};
            end else if (c == 2 * pl + 1) begin e_act = 4'd2;  e_din = ex;  end
            else if (c == 2 * pl + 2)     begin e_act = 4'd7;  e_din = dvw; end
            else if (c == 2 * pl + 3)     begin e_act = 4'd5;  e_din = gr;  end
            else if (c == 2 * pl + 4)     begin e_act = 4'd10; e_din = sh;  end
            else if (c == 2 * pl + 5)     begin e_act = 4'd6;  e_din = enw; end
            check($sformatf("action c=%0d", c), 32'(action), 32'(e_act));
            if (e_act != 4'd0) begin
                check($sformatf("index c=%0d", c), 32'(index), 32'(e_idx));
                check($sformatf("mindex c=%0d", c), 32'(mindex), 32'(sm));
                check($sformatf("din c=%0d", c), din, e_din);
            end
            check($sformatf("busy c=%0d", c), 32'(busy), 32'(c < last));
            check($sformatf("done c=%0d", c), 32'(done), 32'(c == last));
            if (c == 1) check("err_clear", 32'(err), 32'h0);
            if (c == reset_at) begin
                reset = 1'b1;
                @(negedge clk);
                check("rst_action", 32'(action), 32'h0);
                check("rst_busy", 32'(busy), 32'h0);
                check("rst_din", din, 32'h0);
                reset = 1'b0;
                for (int k = 0; k < 2 * pl + 8; k++) begin
                    @(negedge clk);
                    check("no_action_after_rst", 32'(action), 32'h0);
                end
                aborted = 1'b1;
                break;
            end
            if (c == disturb_at) begin
                start = 1'b1;
                div   = 24'($urandom);
            end
            if (c == last && start_at_done) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        if (!aborted && start_at_done) begin
            check("start_at_done_busy", 32'(busy), 32'h0);
            check("start_at_done_action", 32'(action), 32'h0);
        end
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; plen = 6'd0;
        sm_sel = 2'd0; exec_ctrl = '0; div = '0; pin_grps = '0;
        shift_ctrl = '0; en_mask = '0;
        for (int k = 0; k < 32; k++) rom[k] = 16'h0;
        repeat (3) @(negedge clk);
        check("reset_action", 32'(action), 32'h0);
        check("reset_index", 32'(index), 32'h0);
        check("reset_mindex", 32'(mindex), 32'h0);
        check("reset_din", din, 32'h0);
        check("reset_prog_addr", 32'(prog_addr), 32'h0);
        check("reset_busy", 32'(busy), 32'h0);
        check("reset_done", 32'(done), 32'h0);
        check("reset_err", 32'(err), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // bring-up program
        rom[0] = 16'hE020; rom[1] = 16'h2020; rom[2] = 16'h4001; rom[3] = 16'h0002;
        plen = 6'd4; sm_sel = 2'd0; exec_ctrl = 32'h00003000; div = 24'h0;
        pin_grps = 32'h20100000; shift_ctrl = 32'h0; en_mask = 4'h1;
        run_load(-1, -1, 1'b0);

        // empty program on machine 2
        rand_cfg(); sm_sel = 2'd2; plen = 6'd0;
        run_load(-1, -1, 1'b0);

        // full-length program
        rand_rom(); rand_cfg(); plen = 6'd32;
        run_load(-1, -1, 1'b0);

        // oversize program is rejected
        rand_cfg(); plen = 6'd40;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            check("oversize_err", 32'(err), 32'h1);
            check("oversize_action", 32'(action), 32'h0);
            check("oversize_busy", 32'(busy), 32'h0);
            @(negedge clk);
        end
        rand_rom(); plen = 6'd1;
        run_load(-1, -1, 1'b0);

        // start and div change while busy are ignored
        rand_rom(); rand_cfg(); plen = 6'd5;
        run_load(3, -1, 1'b0);

        // reset during the LOAD of index 2, then a full reload
        rand_rom(); rand_cfg(); plen = 6'd4;
        run_load(-1, 6, 1'b0);
        rand_cfg(); plen = 6'd4;
        run_load(-1, -1, 1'b0);

        // start coincident with done is ignored, accepted one cycle later
        rand_rom(); rand_cfg(); plen = 6'd2;
        run_load(-1, -1, 1'b1);
        rand_cfg(); plen = 6'd3;
        run_load(-1, -1, 1'b0);

        // random loads
        for (int n = 0; n < 8; n++) begin
            rand_rom(); rand_cfg();
            plen = 6'($urandom_range(0, 32));
            run_load(-1, -1, 1'($urandom_range(0, 1)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
